// File: rtl/mul_share_arb_pkg.sv
// -----------------------------------------------------------------------------
// mul_share_pkg
//   Shared definitions for the multiplier-sharing arbiter:
//     state_t               : sequencer states (CALC2 only reachable when
//                             MUL_SHARE_ARB_PIPE_EN is defined)
//     MUL_SHARE_NUM_REQ_DEF : default requester count
//     idx_w(n)              : width of an index into n requesters
// -----------------------------------------------------------------------------
package mul_share_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CALC  = 2'd1,
    CALC2 = 2'd2,
    RESP  = 2'd3
  } state_t;

  localparam int MUL_SHARE_NUM_REQ_DEF = 4;

  function automatic int idx_w(input int n);
    return $clog2(n);
  endfunction

endpackage

// File: rtl/mul_share_arb_rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
//   Combinational round-robin grant. Searches req starting at ptr and wrapping
//   modulo N; the first asserted request wins. The pointer itself is owned and
//   advanced by the parent.
// Ports:
//   req      in   N       request vector
//   ptr      in   IW      index with highest priority this cycle
//   en       in   1       allow a grant
//   gnt      out  N       one-hot grant, zero when en=0 or no request
//   gnt_idx  out  IW      index of the granted requester (0 when none)
// -----------------------------------------------------------------------------
module rr_arbiter
  import mul_share_pkg::*;
#(
  parameter int N = MUL_SHARE_NUM_REQ_DEF
) (
  input  logic [N-1:0]        req,
  input  logic [idx_w(N)-1:0] ptr,
  input  logic                en,
  output logic [N-1:0]        gnt,
  output logic [idx_w(N)-1:0] gnt_idx
);

  localparam int IW = idx_w(N);

  // Priority-ordered view: w_rot[k] is requester (ptr+k) mod N.
  logic [N-1:0] w_rot;
  int           w_idx_of [N];

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_rot
      always_comb begin
        w_idx_of[gi] = (int'(ptr) + gi) % N;
        w_rot[gi]    = req[w_idx_of[gi]];
      end
    end
  endgenerate

  always_comb begin
    logic found;
    found   = 1'b0;
    gnt     = '0;
    gnt_idx = '0;
    for (int k = 0; k < N; k++) begin
      if (en && !found && w_rot[k]) begin
        found              = 1'b1;
        gnt[w_idx_of[k]]   = 1'b1;
        gnt_idx            = IW'(w_idx_of[k]);
      end
    end
  end

endmodule

// File: rtl/multi.sv
// -----------------------------------------------------------------------------
// multi
//   Purely combinational unsigned multiplier. The full product is kept, so
//   OUT_DATA_WIDTH must be at least 2*IN_DATA_WIDTH.
// Ports:
//   a  in   IN_DATA_WIDTH   multiplicand
//   b  in   IN_DATA_WIDTH   multiplier
//   p  out  OUT_DATA_WIDTH  a*b
// -----------------------------------------------------------------------------
module multi #(
  parameter int IN_DATA_WIDTH  = 32,
  parameter int OUT_DATA_WIDTH = 64
) (
  input  logic [IN_DATA_WIDTH-1:0]  a,
  input  logic [IN_DATA_WIDTH-1:0]  b,
  output logic [OUT_DATA_WIDTH-1:0] p
);

  // Extend both operands first so the multiply is evaluated at full width.
  assign p = OUT_DATA_WIDTH'(a) * OUT_DATA_WIDTH'(b);

endmodule

// File: rtl/mul_share_arb.sv
// -----------------------------------------------------------------------------
// mul_share_arb
//   Shares one combinational multiplier among NUM_REQ requesters. One operand
//   pair is accepted at a time (round-robin), registered, multiplied, and the
//   product is returned together with the owning requester index.
//   Optional build macro: MUL_SHARE_ARB_PIPE_EN adds a register after the
//   multiplier (extra CALC2 state, latency 3 instead of 2).
// Ports:
//   clk        in   1                      rising-edge clock
//   rst        in   1                      synchronous active-high reset
//   req_valid  in   NUM_REQ                per-requester operand valid
//   req_ready  out  NUM_REQ                per-requester accept (one-hot or 0)
//   req_a      in   NUM_REQ*IN_DATA_WIDTH  multiplicands, k at [k*W +: W]
//   req_b      in   NUM_REQ*IN_DATA_WIDTH  multipliers, same packing
//   rsp_valid  out  1                      product valid
//   rsp_ready  in   1                      downstream accepts product
//   rsp_data   out  OUT_DATA_WIDTH         unsigned product
//   rsp_id     out  ID_W                   owner of rsp_data
//   busy       out  1                      high whenever not IDLE
// -----------------------------------------------------------------------------
module mul_share_arb
  import mul_share_pkg::*;
#(
  parameter int NUM_REQ        = MUL_SHARE_NUM_REQ_DEF,
  parameter int IN_DATA_WIDTH  = 32,
  parameter int OUT_DATA_WIDTH = 64
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_REQ-1:0]               req_valid,
  output logic [NUM_REQ-1:0]               req_ready,
  input  logic [NUM_REQ*IN_DATA_WIDTH-1:0] req_a,
  input  logic [NUM_REQ*IN_DATA_WIDTH-1:0] req_b,
  output logic                             rsp_valid,
  input  logic                             rsp_ready,
  output logic [OUT_DATA_WIDTH-1:0]        rsp_data,
  output logic [idx_w(NUM_REQ)-1:0]        rsp_id,
  output logic                             busy
);

  localparam int ID_W = idx_w(NUM_REQ);
  localparam int W    = IN_DATA_WIDTH;

  state_t                    r_state;
  state_t                    w_state_next;
  logic [ID_W-1:0]           r_rr_ptr;
  logic [W-1:0]              r_a_q;
  logic [W-1:0]              r_b_q;
  logic [ID_W-1:0]           r_id_q;
  logic                      r_rsp_valid;
  logic [OUT_DATA_WIDTH-1:0] r_rsp_data;
  logic [ID_W-1:0]           r_rsp_id;

  logic [W-1:0]              w_a [NUM_REQ];
  logic [W-1:0]              w_b [NUM_REQ];
  logic [NUM_REQ-1:0]        w_gnt;
  logic [ID_W-1:0]           w_gnt_idx;
  logic                      w_arb_en;
  logic                      w_accept;
  logic [OUT_DATA_WIDTH-1:0] w_prod;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign w_a[gi] = req_a[gi*W +: W];
      assign w_b[gi] = req_b[gi*W +: W];
    end
  endgenerate

  // Grants are only offered from IDLE and never while reset is asserted.
  assign w_arb_en = (r_state == IDLE) && !rst;

  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .req     (req_valid),
    .ptr     (r_rr_ptr),
    .en      (w_arb_en),
    .gnt     (w_gnt),
    .gnt_idx (w_gnt_idx)
  );

  multi #(
    .IN_DATA_WIDTH  (IN_DATA_WIDTH),
    .OUT_DATA_WIDTH (OUT_DATA_WIDTH)
  ) u_multi (
    .a (r_a_q),
    .b (r_b_q),
    .p (w_prod)
  );

  assign w_accept  = |w_gnt;
  assign req_ready = w_gnt;
  assign rsp_valid = r_rsp_valid;
  assign rsp_data  = r_rsp_data;
  assign rsp_id    = r_rsp_id;
  assign busy      = (r_state != IDLE);

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:  if (w_accept) w_state_next = CALC;
`ifdef MUL_SHARE_ARB_PIPE_EN
      CALC:  w_state_next = CALC2;
      CALC2: w_state_next = RESP;
`else
      CALC:  w_state_next = RESP;
      CALC2: w_state_next = IDLE;
`endif
      RESP:  if (rsp_ready) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

`ifdef MUL_SHARE_ARB_PIPE_EN
  logic [OUT_DATA_WIDTH-1:0] r_prod_q;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_rr_ptr    <= '0;
      r_a_q       <= '0;
      r_b_q       <= '0;
      r_id_q      <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
      r_rsp_id    <= '0;
`ifdef MUL_SHARE_ARB_PIPE_EN
      r_prod_q    <= '0;
`endif
    end else begin
      r_state <= w_state_next;
      if (w_accept) begin
        r_a_q    <= w_a[w_gnt_idx];
        r_b_q    <= w_b[w_gnt_idx];
        r_id_q   <= w_gnt_idx;
        // The winner drops to lowest priority for the next search.
        r_rr_ptr <= (w_gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : w_gnt_idx + 1'b1;
      end
`ifdef MUL_SHARE_ARB_PIPE_EN
      if (r_state == CALC) begin
        r_prod_q <= w_prod;
      end
      if (r_state == CALC2) begin
        r_rsp_data  <= r_prod_q;
        r_rsp_id    <= r_id_q;
        r_rsp_valid <= 1'b1;
      end
`else
      if (r_state == CALC) begin
        r_rsp_data  <= w_prod;
        r_rsp_id    <= r_id_q;
        r_rsp_valid <= 1'b1;
      end
`endif
      if (r_state == RESP && rsp_ready) begin
        r_rsp_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mul_share_arb.sv
module tb_mul_share_arb;
  import mul_share_pkg::*;

  localparam int N = 4;
  localparam int W = 32;
  localparam int OW = 64;
`ifdef MUL_SHARE_ARB_PIPE_EN
  localparam int EXP_LAT = 3;
`else
  localparam int EXP_LAT = 2;
`endif

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [N*W-1:0]  req_a;
  logic [N*W-1:0]  req_b;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [OW-1:0]   rsp_data;
  logic [1:0]      rsp_id;
  logic            busy;

  int checks = 0;
  int failures = 0;

  mul_share_arb #(.NUM_REQ(N), .IN_DATA_WIDTH(W), .OUT_DATA_WIDTH(OW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_id(rsp_id), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    string        name;
    logic [N-1:0] valid;
    logic [N*W-1:0] a;
    logic [N*W-1:0] b;
    logic [N-1:0] exp_gnt;
    logic [1:0]   exp_id;
    logic [OW-1:0] exp_data;
  } vec_t;

  function automatic logic [N*W-1:0] pk(input logic [W-1:0] x0, input logic [W-1:0] x1,
                                         input logic [W-1:0] x2, input logic [W-1:0] x3);
    return {x3, x2, x1, x0};
  endfunction

  task automatic check(input string name, input logic [OW-1:0] act, input logic [OW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Waits (bounded) for a non-zero req_ready; sampled on the falling edge.
  task automatic wait_grant(input string name, output logic [N-1:0] g);
    g = '0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (req_ready != 0) begin
        g = req_ready;
        break;
      end
    end
    if (g == 0) begin
      checks++;
      failures++;
      $display("FAIL %s: grant timeout got %b expected nonzero", name, g);
    end
  endtask

  // Counts cycles from the accept cycle until rsp_valid is seen.
  task automatic wait_rsp(input string name, output int lat);
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (rsp_valid) begin
        lat = k;
        break;
      end
    end
    if (lat == 0) begin
      checks++;
      failures++;
      $display("FAIL %s: response timeout got 0 expected %0d", name, EXP_LAT);
    end
  endtask

  task automatic do_op(input vec_t v);
    logic [N-1:0] g;
    int lat;
    req_a = v.a;
    req_b = v.b;
    req_valid = v.valid;
    rsp_ready = 1'b1;
    wait_grant({v.name, "_gnt"}, g);
    check({v.name, "_gnt"}, OW'(g), OW'(v.exp_gnt));
    step();
    req_valid = '0;
    wait_rsp({v.name, "_rsp"}, lat);
    check({v.name, "_lat"}, OW'(lat), OW'(EXP_LAT));
    check({v.name, "_data"}, rsp_data, v.exp_data);
    check({v.name, "_id"}, OW'(rsp_id), OW'(v.exp_id));
    $display("op %s gnt=%b id=%0d data=%h lat=%0d", v.name, g, rsp_id, rsp_data, lat);
    step();
  endtask

  vec_t tbl[6];

  initial begin
    logic [N-1:0] g;
    int lat;
    int seen;
    vec_t v;

    // ptr sequence (after the reset test's ptr probe leaves ptr=2):
    // v0 ->0 (ptr1), v1 ->0 (ptr1), v2 ->2 (ptr3), v3 ->3 (ptr0), v4 ->1 (ptr2), v5 ->0 (ptr1)
    tbl[0] = '{"single", 4'b0001, pk(7, 0, 0, 0), pk(6, 0, 0, 0), 4'b0001, 2'd0, 64'd42};
    tbl[1] = '{"fullrange", 4'b0001, pk(32'hFFFF_FFFF, 0, 0, 0), pk(32'hFFFF_FFFF, 0, 0, 0),
               4'b0001, 2'd0, 64'hFFFF_FFFE_0000_0001};
    tbl[2] = '{"zero_a", 4'b0100, pk(0, 0, 0, 0), pk(0, 0, 12345, 0), 4'b0100, 2'd2, 64'd0};
    tbl[3] = '{"wrap3", 4'b1001, pk(5, 0, 0, 1000), pk(5, 0, 0, 3000), 4'b1000, 2'd3, 64'd3000000};
    tbl[4] = '{"ptr0_to1", 4'b1010, pk(0, 32'h1_0000, 0, 9), pk(0, 32'h1_0000, 0, 9),
               4'b0010, 2'd1, 64'h1_0000_0000};
    tbl[5] = '{"wrap_to0", 4'b0011, pk(32'h8000_0000, 4, 0, 0), pk(3, 4, 0, 0),
               4'b0001, 2'd0, 64'h1_8000_0000};

    rst = 1'b1;
    req_valid = 4'b1111;
    req_a = pk(1, 2, 3, 4);
    req_b = pk(1, 2, 3, 4);
    rsp_ready = 1'b1;
    step();
    step();
    @(negedge clk);
    check("rst_req_ready", OW'(req_ready), 0);
    check("rst_rsp_valid", OW'(rsp_valid), 0);
    check("rst_rsp_data", rsp_data, 0);
    check("rst_rsp_id", OW'(rsp_id), 0);
    check("rst_busy", OW'(busy), 0);
    step();
    rst = 1'b0;

    // Round-robin with all requesters held valid: grants 0,1,2,3,0.
    req_a = pk(1, 2, 3, 4);
    req_b = pk(10, 10, 10, 10);
    for (int i = 0; i < 5; i++) begin
      wait_grant("rr_gnt", g);
      check("rr_gnt", OW'(g), OW'(4'b0001 << (i % 4)));
      step();
      wait_rsp("rr_rsp", lat);
      check("rr_id", OW'(rsp_id), OW'(i % 4));
      check("rr_data", rsp_data, OW'(((i % 4) + 1) * 10));
      $display("op rr%0d gnt=%b id=%0d data=%h lat=%0d", i, g, rsp_id, rsp_data, lat);
      step();
    end
    req_valid = '0;
    step();

    // Reset while in CALC: ptr is 1 here, so 0100 grants requester 2.
    req_valid = 4'b0100;
    req_a = pk(0, 0, 11, 0);
    req_b = pk(0, 0, 11, 0);
    wait_grant("rstcalc_gnt", g);
    check("rstcalc_gnt", OW'(g), OW'(4'b0100));
    step();
    req_valid = '0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    check("rstcalc_busy", OW'(busy), 0);
    check("rstcalc_rsp_valid", OW'(rsp_valid), 0);
    seen = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (rsp_valid) seen++;
    end
    check("rstcalc_no_rsp", OW'(seen), 0);
    $display("op rst_in_calc dropped responses=%0d", seen);
    step();
    // ptr must be back at 0: 1010 grants 1 (ptr 3 would have granted 3).
    v = '{"ptr_after_rst", 4'b1010, pk(0, 3, 0, 7), pk(0, 4, 0, 7), 4'b0010, 2'd1, 64'd12};
    do_op(v);

    for (int i = 0; i < 6; i++) do_op(tbl[i]);

    // Backpressure: ptr=1, 0100 grants 2; requester 0 waits meanwhile.
    req_a = pk(5, 0, 9, 0);
    req_b = pk(6, 0, 9, 0);
    req_valid = 4'b0100;
    rsp_ready = 1'b0;
    wait_grant("bp_gnt", g);
    check("bp_gnt", OW'(g), OW'(4'b0100));
    step();
    req_valid = 4'b0001;
    wait_rsp("bp_rsp", lat);
    for (int k = 0; k < 5; k++) begin
      step();
      @(negedge clk);
      check("bp_hold_valid", OW'(rsp_valid), 1);
      check("bp_hold_data", rsp_data, 64'd81);
      check("bp_hold_id", OW'(rsp_id), 2);
      check("bp_hold_ready", OW'(req_ready), 0);
    end
    $display("op backpressure id=%0d data=%h held=5", rsp_id, rsp_data);
    step();
    rsp_ready = 1'b1;
    step();
    @(negedge clk);
    check("bp_next_accept", OW'(req_ready), OW'(4'b0001));
    step();
    req_valid = '0;
    wait_rsp("bp2_rsp", lat);
    check("bp2_data", rsp_data, 64'd30);
    check("bp2_id", OW'(rsp_id), 0);
    $display("op bp_next id=%0d data=%h lat=%0d", rsp_id, rsp_data, lat);
    step();

    // Withdraw: ptr=1, 0110 grants 1; requester 2 then withdraws, 3 asks.
    req_a = pk(0, 2, 50, 8);
    req_b = pk(0, 3, 50, 8);
    req_valid = 4'b0110;
    wait_grant("wd_gnt1", g);
    check("wd_gnt1", OW'(g), OW'(4'b0010));
    step();
    req_valid = 4'b1000;
    wait_rsp("wd_rsp1", lat);
    check("wd_data1", rsp_data, 64'd6);
    step();
    wait_grant("wd_gnt2", g);
    check("wd_gnt2", OW'(g), OW'(4'b1000));
    step();
    req_valid = '0;
    wait_rsp("wd_rsp2", lat);
    check("wd_id2", OW'(rsp_id), 3);
    check("wd_data2", rsp_data, 64'd64);
    $display("op withdraw id=%0d data=%h lat=%0d", rsp_id, rsp_data, lat);
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
